// File: rtl/pool_layer_scheduler.sv
// Sequences a single-channel pool engine across NUM_CHANNELS feature maps,
// relocating the engine's addresses into each channel's slice of memory.
module pool_layer_scheduler #(
   parameter int NUM_CHANNELS   = 8,
   parameter int IN_MAP_SIZE    = 784,
   parameter int OUT_MAP_SIZE   = 196,
   parameter int ADDR_WIDTH     = 16,
   parameter int DRAIN_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   output logic                              engine_run,
   input  logic                              engine_done,
   input  logic [ADDR_WIDTH-1:0]             engine_read_addr,
   input  logic [ADDR_WIDTH-1:0]             engine_write_addr,
   input  logic                              engine_we,
   output logic [ADDR_WIDTH-1:0]             mem_read_addr,
   output logic [ADDR_WIDTH-1:0]             mem_write_addr,
   output logic                              mem_we,
   output logic [$clog2(NUM_CHANNELS+1)-1:0] channel,
   output logic                              busy,
   output logic                              layer_done,
   output logic                              error
);

   localparam int CH_W    = $clog2(NUM_CHANNELS + 1);
   localparam int CNT_MAX = (TIMEOUT_CYCLES > DRAIN_CYCLES) ? TIMEOUT_CYCLES : DRAIN_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CH_W-1:0]       LAST_CH  = CH_W'(NUM_CHANNELS - 1);
   localparam logic [CNT_W-1:0]      TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]      DR_LAST  = CNT_W'(DRAIN_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] IN_STEP  = ADDR_WIDTH'(IN_MAP_SIZE);
   localparam logic [ADDR_WIDTH-1:0] OUT_STEP = ADDR_WIDTH'(OUT_MAP_SIZE);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_DONE = 3'd2,
      S_DRAIN     = 3'd3,
      S_NEXT      = 3'd4,
      S_DONE      = 3'd5,
      S_ERROR     = 3'd6
   } state_t;

   state_t                state_q, state_d;
   logic [CH_W-1:0]       channel_q, channel_d;
   logic [ADDR_WIDTH-1:0] read_base_q, read_base_d;
   logic [ADDR_WIDTH-1:0] write_base_q, write_base_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  error_q, error_d;

   // Next-state logic; one counter serves both the done timeout and the drain hold.
   always_comb begin
      state_d      = state_q;
      channel_d    = channel_q;
      read_base_d  = read_base_q;
      write_base_d = write_base_q;
      cnt_d        = cnt_q;
      error_d      = error_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d      = S_LAUNCH;
               channel_d    = {CH_W{1'b0}};
               read_base_d  = {ADDR_WIDTH{1'b0}};
               write_base_d = {ADDR_WIDTH{1'b0}};
               error_d      = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LAUNCH: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            // done wins over a timeout expiring in the same cycle
            if (engine_done) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_DRAIN;
            end else if (cnt_q == TO_LAST) begin
               cnt_d   = cnt_q + CNT_W'(1);
               error_d = 1'b1;
               state_d = S_ERROR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == DR_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = S_NEXT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_NEXT: begin
            if (channel_q == LAST_CH) begin
               state_d = S_DONE;
            end else begin
               channel_d    = channel_q + CH_W'(1);
               read_base_d  = read_base_q + IN_STEP;
               write_base_d = write_base_q + OUT_STEP;
               state_d      = S_LAUNCH;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERROR: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         channel_q    <= {CH_W{1'b0}};
         read_base_q  <= {ADDR_WIDTH{1'b0}};
         write_base_q <= {ADDR_WIDTH{1'b0}};
         cnt_q        <= {CNT_W{1'b0}};
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         channel_q    <= channel_d;
         read_base_q  <= read_base_d;
         write_base_q <= write_base_d;
         cnt_q        <= cnt_d;
         error_q      <= error_d;
      end
   end

   assign engine_run     = (state_q == S_LAUNCH);
   assign busy           = (state_q != S_IDLE);
   assign layer_done     = (state_q == S_DONE);
   assign error          = error_q;
   assign channel        = channel_q;
   assign mem_read_addr  = engine_read_addr + read_base_q;
   assign mem_write_addr = engine_write_addr + write_base_q;
   // Writes are forwarded until the drain window closes so late ones land in this channel.
   assign mem_we         = engine_we & ((state_q == S_WAIT_DONE) | (state_q == S_DRAIN));

endmodule

// File: tb/tb_pool_layer_scheduler.sv
// Randomized bench for pool_layer_scheduler: expected outputs come from a timeline
// built per layer run from the channel delays, checked every cycle.
module tb_pool_layer_scheduler;

   localparam int NCH = 3, INS = 16, OUTS = 4, AW = 16, DR = 2, TO = 50, MAXC = 512;

   logic          clk = 1'b0, reset = 1'b1, start = 1'b0, engine_done = 1'b0, engine_we = 1'b0;
   logic [AW-1:0] engine_read_addr = '0, engine_write_addr = '0;
   logic [AW-1:0] mem_read_addr, mem_write_addr;
   logic          engine_run, mem_we, busy, layer_done, error;
   logic [1:0]    channel;

   always #5 clk = ~clk;

   pool_layer_scheduler #(
      .NUM_CHANNELS(NCH), .IN_MAP_SIZE(INS), .OUT_MAP_SIZE(OUTS), .ADDR_WIDTH(AW),
      .DRAIN_CYCLES(DR), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .engine_run(engine_run),
      .engine_done(engine_done), .engine_read_addr(engine_read_addr),
      .engine_write_addr(engine_write_addr), .engine_we(engine_we),
      .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr), .mem_we(mem_we),
      .channel(channel), .busy(busy), .layer_done(layer_done), .error(error)
   );

   int n_vec = 0, n_mis = 0;
   int ncyc;
   // expected timeline (per cycle) and stimulus plan
   bit e_busy [MAXC], e_run [MAXC], e_ld [MAXC], e_err [MAXC], e_win [MAXC];
   int e_ch [MAXC];
   bit s_start [MAXC], s_done [MAXC], s_rst [MAXC], f_en [MAXC], f_we [MAXC];
   logic [AW-1:0] f_wa [MAXC];
   int wst [NCH], wen [NCH];
   // observations for literal checks
   bit obs_err [MAXC], obs_we [MAXC];
   logic [AW-1:0] obs_wa [MAXC];
   int run_cnt, ld_cnt;
   // state carried across runs while idle
   int c_ch = 0;
   bit c_err = 1'b0;

   task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", nm, k, act, exp);
      end
   endtask

   task automatic fill(input int k, input bit b, input bit r, input bit l, input bit e,
                       input bit w, input int ch);
      e_busy[k] = b; e_run[k] = r; e_ld[k] = l; e_err[k] = e; e_win[k] = w; e_ch[k] = ch;
   endtask

   task automatic add_noise(input int p);
      for (int k = 0; k < ncyc; k++) begin
         bit in_win = 1'b0;
         for (int c = 0; c < NCH; c++)
            if (k >= wst[c] && k <= wen[c] && wst[c] >= 0) in_win = 1'b1;
         if (!in_win) s_done[k] = ($urandom_range(3) == 0);
      end
      for (int k = p + 1; k <= ncyc - 2; k++) s_start[k] = $urandom_range(1);
   endtask

   // Timeline for one layer run: start pulse in cycle p, done d[c] cycles after each run.
   task automatic build(input int p, input int d0, input int d1, input int d2);
      int dl [NCH];
      int t;
      dl = '{d0, d1, d2};
      for (int k = 0; k < MAXC; k++) begin
         s_start[k] = 0; s_done[k] = 0; s_rst[k] = 0; f_en[k] = 0; f_we[k] = 0; f_wa[k] = '0;
      end
      for (int c = 0; c < NCH; c++) begin wst[c] = -1; wen[c] = -1; end
      for (int k = 0; k <= p; k++) fill(k, 0, 0, 0, c_err, 0, c_ch);
      s_start[p] = 1'b1;
      t = p + 1;
      for (int c = 0; c < NCH; c++) begin
         fill(t, 1, 1, 0, 0, 0, c);
         if (dl[c] <= TO) begin
            for (int k = t + 1; k <= t + dl[c] + DR; k++) fill(k, 1, 0, 0, 0, 1, c);
            wst[c] = t + 1; wen[c] = t + dl[c];
            s_done[t + dl[c]] = 1'b1;
            fill(t + dl[c] + DR + 1, 1, 0, 0, 0, 0, c);
            t = t + dl[c] + DR + 2;
         end else begin
            for (int k = t + 1; k <= t + TO; k++) fill(k, 1, 0, 0, 0, 1, c);
            wst[c] = t + 1; wen[c] = t + TO;
            fill(t + TO + 1, 1, 0, 0, 1, 0, c);
            fill(t + TO + 2, 0, 0, 0, 1, 0, c);
            ncyc = t + TO + 3; c_ch = c; c_err = 1'b1;
            add_noise(p);
            return;
         end
      end
      fill(t, 1, 0, 1, 0, 0, NCH - 1);
      fill(t + 1, 0, 0, 0, 0, 0, NCH - 1);
      ncyc = t + 2; c_ch = NCH - 1; c_err = 1'b0;
      add_noise(p);
   endtask

   // Reset asserted during cycle r: everything back to reset values in cycle r+1.
   task automatic truncate(input int r);
      s_rst[r] = 1'b1;
      fill(r + 1, 0, 0, 0, 0, 0, 0);
      s_start[r + 1] = 1'b0;
      f_en[r + 1] = 1'b1; f_we[r + 1] = 1'b1; f_wa[r + 1] = AW'($urandom);
      ncyc = r + 2; c_ch = 0; c_err = 1'b0;
   endtask

   task automatic run();
      logic [AW-1:0] ra, wa;
      logic we;
      run_cnt = 0; ld_cnt = 0;
      for (int k = 0; k < ncyc; k++) begin
         @(posedge clk); #1;
         ra = AW'($urandom); wa = AW'($urandom); we = 1'($urandom_range(1));
         if (f_en[k]) begin we = f_we[k]; wa = f_wa[k]; end
         reset = s_rst[k]; start = s_start[k]; engine_done = s_done[k];
         engine_read_addr = ra; engine_write_addr = wa; engine_we = we;
         @(negedge clk);
         chk("engine_run", k, 32'(engine_run), 32'(e_run[k]));
         chk("busy", k, 32'(busy), 32'(e_busy[k]));
         chk("layer_done", k, 32'(layer_done), 32'(e_ld[k]));
         chk("error", k, 32'(error), 32'(e_err[k]));
         chk("channel", k, 32'(channel), 32'(e_ch[k]));
         chk("mem_we", k, 32'(mem_we), 32'(we & e_win[k]));
         chk("mem_read_addr", k, 32'(mem_read_addr), 32'(AW'(ra + AW'(e_ch[k] * INS))));
         chk("mem_write_addr", k, 32'(mem_write_addr), 32'(AW'(wa + AW'(e_ch[k] * OUTS))));
         obs_err[k] = error; obs_we[k] = mem_we; obs_wa[k] = mem_write_addr;
         run_cnt += int'(engine_run); ld_cnt += int'(layer_done);
      end
   endtask

   function automatic int pick_delay();
      case ($urandom_range(5))
         0:       return 1;
         1:       return TO - 1;
         2:       return TO;
         3:       return TO + 1 + int'($urandom_range(5));
         default: return int'($urandom_range(20, 2));
      endcase
   endfunction

   initial begin
      int p, r;
      // reset values
      reset = 1'b1; engine_we = 1'b1; engine_read_addr = 16'h1234; engine_write_addr = 16'h0042;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 0, 32'(busy), 32'd0);
      chk("rst_run", 0, 32'(engine_run), 32'd0);
      chk("rst_layer_done", 0, 32'(layer_done), 32'd0);
      chk("rst_error", 0, 32'(error), 32'd0);
      chk("rst_channel", 0, 32'(channel), 32'd0);
      chk("rst_mem_we", 0, 32'(mem_we), 32'd0);
      chk("rst_read_addr", 0, 32'(mem_read_addr), 32'h1234);
      chk("rst_write_addr", 0, 32'(mem_write_addr), 32'h0042);

      // full layer, done 10 cycles after every run; late write on channel 1
      build(0, 10, 10, 10);
      f_en[26] = 1'b1; f_we[26] = 1'b1; f_wa[26] = 16'd3;
      run();
      chk("lit_run_count", 0, 32'(run_cnt), 32'd3);
      chk("lit_layer_done_count", 0, 32'(ld_cnt), 32'd1);
      chk("lit_late_write_addr", 26, 32'(obs_wa[26]), 32'd7);
      chk("lit_late_write_we", 26, 32'(obs_we[26]), 32'd1);

      // channel 0 never completes: error after 50 waiting cycles
      build(0, 999, 5, 5);
      run();
      chk("lit_err_before_timeout", 51, 32'(obs_err[51]), 32'd0);
      chk("lit_err_at_timeout", 52, 32'(obs_err[52]), 32'd1);
      chk("lit_timeout_runs", 0, 32'(run_cnt), 32'd1);
      chk("lit_timeout_no_done", 0, 32'(ld_cnt), 32'd0);

      // next start clears error; done coincident with timeout still completes
      build(2, TO, 1, TO);
      run();
      chk("lit_err_held_idle", 2, 32'(obs_err[2]), 32'd1);
      chk("lit_err_cleared", 3, 32'(obs_err[3]), 32'd0);
      chk("lit_coincident_done", 0, 32'(ld_cnt), 32'd1);

      // reset while waiting on channel 2
      build(1, 5, 5, 30);
      truncate(wst[2] + 3);
      run();
      chk("lit_reset_mem_we", ncyc - 1, 32'(obs_we[ncyc - 1]), 32'd0);

      // randomized runs, some aborted by reset
      repeat (40) begin
         p = int'($urandom_range(3));
         build(p, pick_delay(), pick_delay(), pick_delay());
         if ($urandom_range(4) == 0) begin
            r = int'($urandom_range(ncyc - 2, p + 1));
            truncate(r);
         end
         run();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/pool_layer_scheduler.md
POOL_LAYER_SCHEDULER -- requirements
Module: pool_layer_scheduler

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, 8, feature maps pooled per layer run (>=1).
REQ-002 SHALL have parameter IN_MAP_SIZE, 784, input words per channel map (LAYER_WIDTH*LAYER_HEIGHT of the pool engine).
REQ-003 SHALL have parameter OUT_MAP_SIZE, 196, output words per channel map.
REQ-004 SHALL have parameter ADDR_WIDTH, 16, memory address width.
REQ-005 SHALL have parameter DRAIN_CYCLES, 2, cycles bases are held after engine done so late write enables land in the correct channel (>=1).
REQ-006 SHALL have parameter TIMEOUT_CYCLES, 65535, maximum cycles waiting for engine done per channel.
REQ-007 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port start  input  1  request one full layer run.
REQ-010 SHALL have port engine_run  output  1  one-cycle run pulse to the pool engine.
REQ-011 SHALL have port engine_done  input  1  pool engine completion pulse.
REQ-012 SHALL have port engine_read_addr  input  ADDR_WIDTH  engine-relative read address.
REQ-013 SHALL have port engine_write_addr  input  ADDR_WIDTH  engine-relative write address.
REQ-014 SHALL have port engine_we  input  1  engine write enable.
REQ-015 SHALL have port mem_read_addr  output  ADDR_WIDTH  absolute read address.
REQ-016 SHALL have port mem_write_addr  output  ADDR_WIDTH  absolute write address.
REQ-017 SHALL have port mem_we  output  1  gated write enable.
REQ-018 SHALL have port channel  output  $clog2(NUM_CHANNELS+1)  index of channel in progress.
REQ-019 SHALL have port busy  output  1  high from accepted start until DONE/ERROR exit.
REQ-020 SHALL have port layer_done  output  1  one-cycle pulse, all channels complete.
REQ-021 SHALL have port error  output  1  sticky timeout flag.

Function
REQ-022 SHALL implement states IDLE, LAUNCH, WAIT_DONE, DRAIN, NEXT, DONE, ERROR.
REQ-023 IDLE: start=1 -> LAUNCH, channel/read_base/write_base cleared to 0, error cleared; start in any other state SHALL be ignored.
REQ-024 LAUNCH: engine_run=1 for exactly this cycle; timeout counter cleared; -> WAIT_DONE.
REQ-025 WAIT_DONE: engine_done=1 -> DRAIN; else counter increments; counter reaching TIMEOUT_CYCLES -> ERROR.
REQ-026 DRAIN: held exactly DRAIN_CYCLES cycles, bases unchanged -> NEXT.
REQ-027 NEXT: if channel==NUM_CHANNELS-1 -> DONE; else channel+1, read_base+=IN_MAP_SIZE, write_base+=OUT_MAP_SIZE, -> LAUNCH.
REQ-028 DONE: layer_done=1 one cycle -> IDLE; ERROR: error=1 (sticky), -> IDLE next cycle, no layer_done.
REQ-029 mem_read_addr = engine_read_addr + read_base, mem_write_addr = engine_write_addr + write_base, combinational, modulo 2^ADDR_WIDTH.
REQ-030 mem_we = engine_we AND state in {WAIT_DONE, DRAIN}; otherwise 0.
REQ-031 engine_done outside WAIT_DONE SHALL be ignored; engine_done coincident with timeout expiry SHALL take DRAIN.
REQ-032 busy=1 in LAUNCH..DONE and ERROR, 0 in IDLE; launch latency start->engine_run = 1 cycle.

Reset
REQ-033 reset SHALL force IDLE in the next cycle, including mid-layer, discarding progress.
REQ-034 Reset values: engine_run=0, mem_we=0, busy=0, layer_done=0, error=0, channel=0, read_base=0, write_base=0, timeout counter=0.

Verification (NUM_CHANNELS=3, IN_MAP_SIZE=16, OUT_MAP_SIZE=4, DRAIN_CYCLES=2, TIMEOUT_CYCLES=50)
REQ-035 start pulse, engine model done 10 cycles after each run -> 3 engine_run pulses, channel 0,1,2, read bases 0/16/32, write bases 0/4/8, single layer_done, busy low after.
REQ-036 engine_we with engine_write_addr=3 one cycle after done on channel 1 -> mem_write_addr=7, mem_we=1.
REQ-037 no engine_done on channel 0 -> error=1 after 50 WAIT_DONE cycles, no layer_done, IDLE; next start clears error.
REQ-038 reset asserted in WAIT_DONE of channel 2 -> next cycle all outputs at reset values; engine_we ignored (mem_we=0).
REQ-039 start held high during run and spurious engine_done in IDLE/DRAIN -> no extra launches, no state change.
